// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Combinational-only definitions; no latency or backpressure of its own.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    localparam int DEF_REG_ADDR_WIDTH = 5;

    // Bit positions inside the stall/flush vectors.
    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

endpackage

// File: rtl/load_use_detect.sv
// Flags a RAW hazard between a load in EX and a source read in ID.
// Zero latency, purely combinational; no backpressure.
module load_use_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    output logic                      hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard  = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline plus saturating perf counters.
// Controls are combinational same-cycle; memory wait freezes everything.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int MC_LATENCY     = 8,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    input  logic                      ex_branch_taken,
    input  logic                      ex_mc_op,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_en,
    output logic                      stall_if_id,
    output logic                      stall_id_ex,
    output logic                      stall_ex_mem,
    output logic                      stall_mem_wb,
    output logic                      flush_if_id,
    output logic                      flush_id_ex,
    output logic                      flush_ex_mem,
    output logic                      mc_busy,
    output logic [PERF_WIDTH-1:0]     perf_stall_cycles,
    output logic [PERF_WIDTH-1:0]     perf_flushes
);

    state_t                state_q, state_d;
    logic [7:0]            mc_cnt_q, mc_cnt_d;
    logic [PERF_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
    logic [3:0]            stall_v;
    logic [2:0]            flush_v;
    logic                  pc_en_v;
    logic                  flush_evt;
    logic                  hazard;
    logic                  mem_hold;

    load_use_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_lud (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (hazard)
    );

    assign mem_hold = mem_req & ~mem_ready;

    always_comb begin
        state_d   = state_q;
        mc_cnt_d  = mc_cnt_q;
        stall_v   = '0;
        flush_v   = '0;
        pc_en_v   = 1'b1;
        flush_evt = 1'b0;
        if (reset) begin
            pc_en_v  = 1'b0;
            state_d  = RUN;
            mc_cnt_d = '0;
        end else if (mem_hold) begin
            stall_v = '1;
            pc_en_v = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_mc_op) begin
                        pc_en_v             = 1'b0;
                        stall_v[STG_IF_ID]  = 1'b1;
                        stall_v[STG_ID_EX]  = 1'b1;
                        flush_v[STG_EX_MEM] = 1'b1;
                        mc_cnt_d            = 8'(MC_LATENCY - 2);
                        state_d             = MC_BUSY;
                    end else if (ex_branch_taken) begin
                        flush_v[STG_IF_ID] = 1'b1;
                        flush_v[STG_ID_EX] = 1'b1;
                        flush_evt          = 1'b1;
                    end else if (hazard) begin
                        pc_en_v            = 1'b0;
                        stall_v[STG_IF_ID] = 1'b1;
                        flush_v[STG_ID_EX] = 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt_q != '0) begin
                        pc_en_v             = 1'b0;
                        stall_v[STG_IF_ID]  = 1'b1;
                        stall_v[STG_ID_EX]  = 1'b1;
                        flush_v[STG_EX_MEM] = 1'b1;
                        mc_cnt_d            = mc_cnt_q - 8'd1;
                    end else begin
                        // Release: EX/MEM captures the result; the op is still in EX.
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            if (!pc_en_v && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_evt && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign pc_en             = pc_en_v;
    assign stall_if_id       = stall_v[STG_IF_ID];
    assign stall_id_ex       = stall_v[STG_ID_EX];
    assign stall_ex_mem      = stall_v[STG_EX_MEM];
    assign stall_mem_wb      = stall_v[STG_MEM_WB];
    assign flush_if_id       = flush_v[STG_IF_ID];
    assign flush_id_ex       = flush_v[STG_ID_EX];
    assign flush_ex_mem      = flush_v[STG_EX_MEM];
    assign mc_busy           = !reset && (state_q == MC_BUSY);
    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flushes      = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench with an expectation queue drained by a negedge monitor.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, ex_mc_op;
    logic       mem_req, mem_ready;

    logic        pc_en, s_ifid, s_idex, s_exmem, s_memwb, f_ifid, f_idex, f_exmem, busy;
    logic [31:0] perf_sc, perf_fc;
    logic        pc_en_b, s_ifid_b, s_idex_b, s_exmem_b, s_memwb_b, f_ifid_b, f_idex_b, f_exmem_b, busy_b;
    logic [3:0]  sat_sc, sat_fc;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MC_LATENCY(8), .PERF_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .ex_mc_op(ex_mc_op),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en),
        .stall_if_id(s_ifid), .stall_id_ex(s_idex), .stall_ex_mem(s_exmem), .stall_mem_wb(s_memwb),
        .flush_if_id(f_ifid), .flush_id_ex(f_idex), .flush_ex_mem(f_exmem), .mc_busy(busy),
        .perf_stall_cycles(perf_sc), .perf_flushes(perf_fc)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MC_LATENCY(8), .PERF_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .ex_mc_op(ex_mc_op),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en_b),
        .stall_if_id(s_ifid_b), .stall_id_ex(s_idex_b), .stall_ex_mem(s_exmem_b), .stall_mem_wb(s_memwb_b),
        .flush_if_id(f_ifid_b), .flush_id_ex(f_idex_b), .flush_ex_mem(f_exmem_b), .mc_busy(busy_b),
        .perf_stall_cycles(sat_sc), .perf_flushes(sat_fc)
    );

    typedef struct {
        string      name;
        logic [8:0] ctl;
        bit         chk_cnt;
        int         sc;
        int         fc;
        bit         chk_sat;
        int         sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // ctl = {pc_en, stall[mem_wb,ex_mem,id_ex,if_id], flush[ex_mem,id_ex,if_id], mc_busy}
    task automatic expect_cyc(input string nm, input logic pc, input logic [3:0] st,
                              input logic [2:0] fl, input logic bz,
                              input bit cc, input int sc, input int fc,
                              input bit cs, input int sv);
        exp_t e;
        e.name = nm; e.ctl = {pc, st, fl, bz};
        e.chk_cnt = cc; e.sc = sc; e.fc = fc; e.chk_sat = cs; e.sat = sv;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        reset = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_mc_op = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_en, s_memwb, s_exmem, s_idex, s_ifid, f_exmem, f_idex, f_ifid, busy};
                n_cmp++;
                if (act !== e.ctl) begin
                    n_err++;
                    $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
                end
                if (e.chk_cnt) begin
                    n_cmp++;
                    if (perf_sc !== 32'(e.sc) || perf_fc !== 32'(e.fc)) begin
                        n_err++;
                        $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                                 e.name, perf_sc, perf_fc, e.sc, e.fc);
                    end
                end
                if (e.chk_sat) begin
                    n_cmp++;
                    if (sat_sc !== 4'(e.sat)) begin
                        n_err++;
                        $display("FAIL %s sat_stall: got %0d want %0d", e.name, sat_sc, e.sat);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        idle_in();
        reset = 1'b1;
        @(posedge clk); #1;
        expect_cyc("reset0", 0, 4'b0000, 3'b000, 0, 1, 0, 0, 1, 0);
        expect_cyc("reset1", 0, 4'b0000, 3'b000, 0, 1, 0, 0, 1, 0);
        idle_in();
        expect_cyc("idle",   1, 4'b0000, 3'b000, 0, 1, 0, 0, 0, 0);

        // Load-use on rs2.
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
        expect_cyc("lu_rs2", 0, 4'b0001, 3'b010, 0, 1, 0, 0, 0, 0);
        idle_in();
        expect_cyc("lu_after", 1, 4'b0000, 3'b000, 0, 1, 1, 0, 0, 0);
        // Load into x0 is never a hazard.
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_rs2_used = 1;
        expect_cyc("lu_x0", 1, 4'b0000, 3'b000, 0, 1, 1, 0, 0, 0);
        // Matching rs1 but unused: no hazard.
        ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        expect_cyc("lu_unused", 1, 4'b0000, 3'b000, 0, 1, 1, 0, 0, 0);
        id_rs1_used = 1;
        expect_cyc("lu_rs1", 0, 4'b0001, 3'b010, 0, 1, 1, 0, 0, 0);
        idle_in();
        expect_cyc("lu_rs1_after", 1, 4'b0000, 3'b000, 0, 1, 2, 0, 0, 0);

        // Taken branch overrides a simultaneous load-use.
        ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
        expect_cyc("branch", 1, 4'b0000, 3'b011, 0, 1, 2, 0, 0, 0);
        idle_in();
        expect_cyc("branch_after", 1, 4'b0000, 3'b000, 0, 1, 2, 1, 0, 0);

        // Multicycle, latency 8.
        ex_mc_op = 1;
        expect_cyc("mc_c1", 0, 4'b0011, 3'b100, 0, 1, 2, 1, 0, 0);
        for (int k = 2; k <= 7; k++)
            expect_cyc($sformatf("mc_c%0d", k), 0, 4'b0011, 3'b100, 1, 1, 1 + k, 1, 0, 0);
        expect_cyc("mc_release", 1, 4'b0000, 3'b000, 1, 1, 9, 1, 0, 0);
        idle_in();
        expect_cyc("mc_done", 1, 4'b0000, 3'b000, 0, 1, 9, 1, 0, 0);

        // Multicycle with a 3-cycle memory hold starting at busy cycle 3.
        ex_mc_op = 1;
        expect_cyc("mh_c1", 0, 4'b0011, 3'b100, 0, 1, 9, 1, 0, 0);
        expect_cyc("mh_c2", 0, 4'b0011, 3'b100, 1, 1, 10, 1, 0, 0);
        mem_req = 1; mem_ready = 0;
        for (int k = 3; k <= 5; k++)
            expect_cyc($sformatf("mh_hold%0d", k), 0, 4'b1111, 3'b000, 1, 1, 8 + k, 1, 0, 0);
        mem_req = 0;
        for (int k = 6; k <= 10; k++)
            expect_cyc($sformatf("mh_c%0d", k), 0, 4'b0011, 3'b100, 1, 1, 8 + k, 1, 0, 0);
        expect_cyc("mh_release11", 1, 4'b0000, 3'b000, 1, 1, 19, 1, 0, 0);
        idle_in();
        expect_cyc("mh_done", 1, 4'b0000, 3'b000, 0, 1, 19, 1, 0, 0);

        // Memory hold in RUN suppresses a branch flush; ready completes the access.
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        expect_cyc("hold_br", 0, 4'b1111, 3'b000, 0, 1, 19, 1, 0, 0);
        ex_branch_taken = 0; mem_ready = 1;
        expect_cyc("mem_ready", 1, 4'b0000, 3'b000, 0, 1, 20, 1, 0, 0);
        idle_in();

        // Reset at busy cycle 4 aborts the op.
        ex_mc_op = 1;
        expect_cyc("rs_c1", 0, 4'b0011, 3'b100, 0, 1, 20, 1, 0, 0);
        expect_cyc("rs_c2", 0, 4'b0011, 3'b100, 1, 1, 21, 1, 0, 0);
        expect_cyc("rs_c3", 0, 4'b0011, 3'b100, 1, 1, 22, 1, 0, 0);
        reset = 1;
        expect_cyc("rs_c4", 0, 4'b0000, 3'b000, 0, 0, 0, 0, 0, 0);
        idle_in();
        expect_cyc("rs_after", 1, 4'b0000, 3'b000, 0, 1, 0, 0, 1, 0);

        // 20 load-use stall cycles; the 4-bit counter saturates at 15.
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_rs1_used = 1;
        for (int k = 1; k <= 20; k++)
            expect_cyc($sformatf("sat_k%0d", k), 0, 4'b0001, 3'b010, 0, 1, k - 1, 0,
                       (k >= 14), (k - 1 > 15) ? 15 : k - 1);
        idle_in();
        expect_cyc("sat_final", 1, 4'b0000, 3'b000, 0, 1, 20, 0, 1, 15);
        expect_cyc("sat_hold", 1, 4'b0000, 3'b000, 0, 1, 20, 0, 1, 15);

        @(posedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage processor pipeline. It drives the `stall` inputs of the four `pipeline_register` instances (IF/ID, ID/EX, EX/MEM, MEM/WB) and generates per-stage flush requests. Flush requests are ORed into each register's `reset` port; an all-zero control word is a NOP bubble. It sequences load-use bubbles, taken-branch squashes, fixed-latency multicycle EX operations (iterative multiply for factorial) and memory wait freezes, and keeps saturating performance counters.

## Interface
- `REG_ADDR_WIDTH`, default 5: register specifier width.
- `MC_LATENCY`, default 8: total cycles a multicycle op occupies EX; legal range 2..255.
- `PERF_WIDTH`, default 32: width of the performance counters.

- `clk`  in  1  pipeline clock.
- `reset`  in  1  synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  REG_ADDR_WIDTH each  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the corresponding source is read.
- `ex_rd`  in  REG_ADDR_WIDTH  destination of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_branch_taken`  in  1  the EX instruction resolved a taken branch or jump.
- `ex_mc_op`  in  1  the EX instruction is a multicycle op.
- `mem_req`, `mem_ready`  in  1 each  the MEM stage has an access outstanding / the access completes this cycle.
- `pc_en`  out  1  PC update enable.
- `stall_if_id`, `stall_id_ex`, `stall_ex_mem`, `stall_mem_wb`  out  1 each  hold the register.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem`  out  1 each  load a bubble into the register.
- `mc_busy`  out  1  a multicycle op is in progress.
- `perf_stall_cycles`, `perf_flushes`  out  PERF_WIDTH each  saturating counters.

## Operation
- FSM states:
  - `RUN` (reset state).
  - `MC_BUSY`, with a down-counter `mc_cnt` of width 8.
- `mem_hold = mem_req & ~mem_ready` is the global freeze and has top priority.
  - All four stalls are 1, `pc_en` is 0 and all flushes are 0.
  - The FSM, `mc_cnt` and the branch/load-use/multicycle logic are frozen.
- RUN, priority order when `mem_hold` is 0:
  1. `ex_mc_op`:
     - Set `pc_en`=0, `stall_if_id`=1, `stall_id_ex`=1 and `flush_ex_mem`=1.
     - Load `mc_cnt` with MC_LATENCY-2 and go to `MC_BUSY`.
     - `ex_branch_taken` is ignored; decode guarantees the two are exclusive.
  2. `ex_branch_taken`:
     - Set `flush_if_id`=1, `flush_id_ex`=1 and `pc_en`=1 (PC loads the target).
     - Increment `perf_flushes`.
     - Overrides any load-use hazard, because the ID instruction is wrong-path.
  3. Load-use:
     - Condition: `ex_mem_read`, `ex_rd` not 0, and a used `id_rsN` equals `ex_rd`.
     - Set `pc_en`=0, `stall_if_id`=1 and `flush_id_ex`=1.
  4. Otherwise set `pc_en`=1, all stalls to 0 and all flushes to 0.
- MC_BUSY:
  - While `mc_cnt` is not 0: set `pc_en`=0, `stall_if_id`=1, `stall_id_ex`=1, `flush_ex_mem`=1 and `mc_busy`=1, then decrement.
  - When `mc_cnt` is 0 (release cycle):
    - Outputs are all 0 and `pc_en`=1, so EX/MEM captures the result.
    - `mc_busy` is 1 and the FSM returns to `RUN`.
    - `ex_mc_op` is ignored, because the same op is still visible in EX.
- `stall_mem_wb` is 1 only during `mem_hold`.
- `perf_stall_cycles` increments on every non-reset cycle with `pc_en`=0.
- Both counters saturate at all-ones and never wrap.
- Reset values:
  - State: `RUN`, `mc_cnt`=0, both counters 0.
  - While `reset`=1 the outputs are forced to `pc_en`=0, all stalls 0, all flushes 0 and `mc_busy`=0.
  - The pipeline registers clear themselves through their own reset.
- Reset mid-multicycle aborts the op and returns to `RUN` on the next cycle.

## Timing
- All outputs except the counters are combinational in the same cycle from the current state and inputs.
- No input-to-output path crosses a flop other than the FSM state and `mc_cnt`.
- Load-use costs exactly 1 bubble.
- A taken branch costs 2 squashed slots, with 0 stall cycles.
- A multicycle op holds EX for exactly MC_LATENCY cycles: 1 cycle in RUN plus MC_LATENCY-1 cycles in MC_BUSY. It inserts MC_LATENCY-1 bubbles into EX/MEM.
- A `mem_hold` arriving during MC_BUSY extends the op by the number of hold cycles; `mc_cnt` does not decrement.
- The counters update at the clock edge following the event.
- `mc_busy` is registered-state derived: it is 1 for all MC_LATENCY-1 MC_BUSY cycles, including the release cycle, and 0 in RUN.

## Structure
- Package `pipe_ctrl_pkg`:
  - Holds the FSM state enum (`RUN`, `MC_BUSY`) and the default `REG_ADDR_WIDTH`.
  - Holds the stage-index constants used to index the stall/flush vectors.
- One sub-module, `load_use_detect`:
  - Purely combinational: `id_rs1`, `id_rs2`, the used flags, `ex_rd` and `ex_mem_read` in; `hazard` out.
  - Instantiated once.
- The top level contains the FSM, the priority mux and the counters.

## Test plan
- Load-use:
  - Stimulus: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_rs2_used`=1 for 1 cycle.
  - Response: `pc_en`=0, `stall_if_id`=1, `flush_id_ex`=1. `perf_stall_cycles` 0->1.
  - Repeat with `ex_rd`=0: no stall.
- Branch:
  - Stimulus: `ex_branch_taken`=1 with a simultaneous load-use hazard.
  - Response: `flush_if_id`=1, `flush_id_ex`=1, `pc_en`=1. `perf_flushes` 0->1.
- Multicycle with MC_LATENCY=8:
  - Stimulus: `ex_mc_op` held 1 continuously.
  - Response: `pc_en`=0 for 7 consecutive cycles, release on cycle 8, then back to `RUN`.
  - `flush_ex_mem`=1 on 7 cycles and `mc_busy`=1 on cycles 2..8.
- Memory wait inside multicycle:
  - Stimulus: `mem_req`=1, `mem_ready`=0 for 3 cycles starting at busy cycle 3.
  - Response: all four stalls are 1 and all flushes 0 for those 3 cycles.
  - The op releases on cycle 11 instead of 8.
- Reset:
  - Stimulus: assert `reset` at busy cycle 4.
  - Response: outputs are forced to 0 during reset, the state is `RUN` afterwards, and the counters are 0.
- Saturation:
  - Stimulus: with PERF_WIDTH=4, cause 20 stall cycles.
  - Response: `perf_stall_cycles` holds at 15.
